// File: rtl/finder_pkg.sv
// Shared definitions for the finder core and its input-side vector packer.
package finder_pkg;

  // Default geometry of the core; modules carry their own parameters too.
  localparam int FINDER_N            = 16;
  localparam int FINDER_WIDTH_VECTOR = 16;

  // One full vector as seen by the core: lane 0 holds the first sample.
  typedef logic [FINDER_WIDTH_VECTOR-1:0][FINDER_N-1:0] vector_t;

  // Packer states: FILL while samples can be taken, WAIT while a finished
  // vector is parked in the assembly register behind a full output stage.
  typedef enum logic {
    FILL = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/vector_packer_hold.sv
// Single-entry output stage of the vector packer: holds one finished vector
// and presents it to the FIFO write port until the FIFO takes it.
module vector_packer_hold #(
  parameter int N            = 16,
  parameter int WIDTH_VECTOR = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [WIDTH_VECTOR-1:0][N-1:0]   load_data,
  input  logic                             load_pad,
  input  logic                             fifo_full,
  output logic [WIDTH_VECTOR-1:0][N-1:0]   hold_data,
  output logic                             hold_valid,
  output logic                             pad_flag,
  output logic                             winc
);

  logic hold_pad;

  // A write happens whenever something is held and the FIFO has room; reset
  // blocks it so a pending vector is dropped rather than written.
  assign winc     = hold_valid && !fifo_full && !rst;
  assign pad_flag = hold_valid && hold_pad;

  // Load has priority over drain so a vector closing in the draining cycle
  // replaces the outgoing one without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_pad   <= 1'b0;
    end else if (load) begin
      hold_data  <= load_data;
      hold_valid <= 1'b1;
      hold_pad   <= load_pad;
    end else if (winc) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vector_packer.sv
// Input-side packer: gathers WIDTH_VECTOR serial samples into one vector and
// writes it into the core's vector FIFO, honouring FIFO backpressure.
module vector_packer
  import finder_pkg::*;
#(
  parameter int             N            = 16,
  parameter int             WIDTH_VECTOR = 16,
  parameter logic [N-1:0]   PAD_VALUE    = '0,
  parameter int             CNT_W        = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N-1:0]                     s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic                             s_last,
  input  logic                             fifo_full,
  output logic [WIDTH_VECTOR-1:0][N-1:0]   fifo_wdata,
  output logic                             fifo_winc,
  output logic [CNT_W-1:0]                 vec_count,
  output logic                             pad_flag
);

  localparam int IDX_W = (WIDTH_VECTOR > 1) ? $clog2(WIDTH_VECTOR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH_VECTOR - 1);
  localparam logic [WIDTH_VECTOR-1:0][N-1:0] PAD_VEC = {WIDTH_VECTOR{PAD_VALUE}};

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [WIDTH_VECTOR-1:0][N-1:0]  asm_reg;
  logic                            asm_pad;

  logic                            accept;
  logic                            close;
  logic [WIDTH_VECTOR-1:0][N-1:0]  closed_vec;
  logic                            closed_pad;

  logic                            hold_load;
  logic [WIDTH_VECTOR-1:0][N-1:0]  hold_in;
  logic                            hold_in_pad;
  logic                            hold_valid;

  assign s_ready    = (state == FILL) && !rst;
  assign accept     = s_valid && s_ready;
  assign close      = accept && (s_last || (idx == LAST_IDX));
  assign closed_pad = (idx != LAST_IDX);

  // The vector as it would look if closed by the current sample: lanes below
  // idx keep what was assembled, lane idx takes s_data, lanes above get PAD.
  always_comb begin
    closed_vec = asm_reg;
    for (int l = 0; l < WIDTH_VECTOR; l++) begin
      if (IDX_W'(l) == idx) begin
        closed_vec[l] = s_data;
      end else if (IDX_W'(l) > idx) begin
        closed_vec[l] = PAD_VALUE;
      end
    end
  end

  // Decide what enters the output stage: a freshly closed vector when the
  // stage is free or draining, or the parked vector once the stage drains.
  always_comb begin
    hold_load   = 1'b0;
    hold_in     = closed_vec;
    hold_in_pad = closed_pad;
    if (state == FILL) begin
      if (close && (!hold_valid || fifo_winc)) begin
        hold_load = 1'b1;
      end
    end else begin
      if (fifo_winc) begin
        hold_load   = 1'b1;
        hold_in     = asm_reg;
        hold_in_pad = asm_pad;
      end
    end
  end

  // Lane writes, parking of a second vector, and the FILL/WAIT sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      asm_reg   <= PAD_VEC;
      asm_pad   <= 1'b0;
      vec_count <= '0;
    end else begin
      if (fifo_winc) begin
        vec_count <= vec_count + CNT_W'(1);
      end
      unique case (state)
        FILL: begin
          if (accept) begin
            if (close) begin
              idx <= '0;
              if (hold_load) begin
                asm_reg <= PAD_VEC;
              end else begin
                asm_reg <= closed_vec;
                asm_pad <= closed_pad;
                state   <= WAIT;
              end
            end else begin
              asm_reg[idx] <= s_data;
              idx          <= idx + IDX_W'(1);
            end
          end
        end
        WAIT: begin
          if (fifo_winc) begin
            asm_reg <= PAD_VEC;
            asm_pad <= 1'b0;
            idx     <= '0;
            state   <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  vector_packer_hold #(
    .N            (N),
    .WIDTH_VECTOR (WIDTH_VECTOR)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .load_data  (hold_in),
    .load_pad   (hold_in_pad),
    .fifo_full  (fifo_full),
    .hold_data  (fifo_wdata),
    .hold_valid (hold_valid),
    .pad_flag   (pad_flag),
    .winc       (fifo_winc)
  );

endmodule

// File: tb/tb_vector_packer.sv
// Directed self-checking bench for vector_packer: streaming, short frames,
// backpressure, close-while-draining, mid-vector reset and counter wrap.
module tb_vector_packer;

  localparam int           N   = 16;
  localparam int           WV  = 16;
  localparam logic [N-1:0] PAD = 16'hBEEF;

  logic                   clk;
  logic                   rst;
  logic [N-1:0]           s_data;
  logic                   s_valid;
  logic                   s_last;
  logic                   fifo_full;
  logic                   s_ready;
  logic [WV-1:0][N-1:0]   fifo_wdata;
  logic                   fifo_winc;
  logic [15:0]            vec_count;
  logic                   pad_flag;

  logic                   s_ready2;
  logic [WV-1:0][N-1:0]   fifo_wdata2;
  logic                   fifo_winc2;
  logic [1:0]             vec_count2;
  logic                   pad_flag2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int stalls = 0;

  logic [255:0] wr_data[$];
  logic         wr_pad[$];
  int           wr_cycle[$];

  vector_packer #(.N(N), .WIDTH_VECTOR(WV), .PAD_VALUE(PAD), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .fifo_full(fifo_full), .fifo_wdata(fifo_wdata),
    .fifo_winc(fifo_winc), .vec_count(vec_count), .pad_flag(pad_flag)
  );

  vector_packer #(.N(N), .WIDTH_VECTOR(WV), .PAD_VALUE(PAD), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
    .s_last(s_last), .fifo_full(fifo_full), .fifo_wdata(fifo_wdata2),
    .fifo_winc(fifo_winc2), .vec_count(vec_count2), .pad_flag(pad_flag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after active edge k, cyc reads k.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every FIFO write mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (fifo_winc === 1'b1) begin
      wr_data.push_back(fifo_wdata);
      wr_pad.push_back(pad_flag);
      wr_cycle.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [255:0] make_vec(input logic [N-1:0] base, input int n);
    logic [255:0] v;
    for (int l = 0; l < WV; l++) begin
      v[l*N +: N] = (l < n) ? base + N'(l) : PAD;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_log();
    wr_data.delete();
    wr_pad.delete();
    wr_cycle.delete();
  endtask

  task automatic applyReset();
    s_valid   = 1'b0;
    s_last    = 1'b0;
    fifo_full = 1'b0;
    rst       = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("rst_ready_low", s_ready, 1'b0);
    checkOutput("rst_winc_low", fifo_winc, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", s_ready, 1'b1);
    checkOutput("post_rst_winc", fifo_winc, 1'b0);
    checkOutput("post_rst_wdata", fifo_wdata, '0);
    checkOutput("post_rst_pad", pad_flag, 1'b0);
    checkOutput("post_rst_count", vec_count, '0);
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and return the edge number at which it is accepted.
  task automatic applyStimulus(input logic [N-1:0] data, input logic last,
                               output int accept_edge);
    int waits;
    waits   = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    forever begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      waits++;
      if (waits > 100) begin
        checkOutput("accept_timeout", 1'b1, 1'b0);
        accept_edge = -1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        return;
      end
    end
    accept_edge = cyc + 1;
    if (waits > 0) stalls++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e, e15, e31, e32;
    int wrap_exp[5] = '{1, 2, 3, 0, 1};
    logic [255:0] short_vec;

    rst       = 1'b1;
    s_data    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    fifo_full = 1'b0;

    // Streaming: 32 samples back to back, two full vectors.
    applyReset();
    clear_log();
    stalls = 0;
    e15 = -1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(N'(i), 1'b0, e);
      if (i == 15) e15 = e;
    end
    idle(3);
    checkOutput("stream_writes", wr_data.size(), 2);
    checkOutput("stream_stalls", stalls, 0);
    checkOutput("stream_count", vec_count, 16'd2);
    if (wr_data.size() >= 2) begin
      checkOutput("stream_vec0", wr_data[0], make_vec(16'd0, 16));
      checkOutput("stream_vec1", wr_data[1], make_vec(16'd16, 16));
      checkOutput("stream_pad0", wr_pad[0], 1'b0);
      checkOutput("stream_pad1", wr_pad[1], 1'b0);
      checkOutput("stream_latency", wr_cycle[0], e15);
    end

    // Short frame closed by s_last after three samples.
    applyReset();
    clear_log();
    applyStimulus(16'hA0A0, 1'b0, e);
    applyStimulus(16'hB1B1, 1'b0, e);
    applyStimulus(16'hC2C2, 1'b1, e);
    idle(3);
    short_vec = {16{PAD}};
    short_vec[15:0]  = 16'hA0A0;
    short_vec[31:16] = 16'hB1B1;
    short_vec[47:32] = 16'hC2C2;
    checkOutput("short_writes", wr_data.size(), 1);
    if (wr_data.size() >= 1) begin
      checkOutput("short_vec", wr_data[0], short_vec);
      checkOutput("short_pad", wr_pad[0], 1'b1);
    end
    checkOutput("short_count", vec_count, 16'd1);

    // Backpressure: two vectors buffered, then released.
    applyReset();
    clear_log();
    fifo_full = 1'b1;
    for (int i = 0; i < 32; i++) applyStimulus(N'(i), 1'b0, e);
    s_valid = 1'b1;
    s_data  = 16'd32;
    s_last  = 1'b0;
    @(negedge clk);
    checkOutput("bp_ready_low", s_ready, 1'b0);
    checkOutput("bp_winc_low", fifo_winc, 1'b0);
    checkOutput("bp_hold_data", fifo_wdata, make_vec(16'd0, 16));
    repeat (4) @(negedge clk);
    checkOutput("bp_hold_stable", fifo_wdata, make_vec(16'd0, 16));
    checkOutput("bp_still_stalled", s_ready, 1'b0);
    checkOutput("bp_no_writes", wr_data.size(), 0);
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    applyStimulus(16'd32, 1'b0, e32);
    idle(3);
    checkOutput("bp_writes", wr_data.size(), 2);
    if (wr_data.size() >= 2) begin
      checkOutput("bp_vec0", wr_data[0], make_vec(16'd0, 16));
      checkOutput("bp_vec1", wr_data[1], make_vec(16'd16, 16));
      checkOutput("bp_back_to_back", wr_cycle[1], wr_cycle[0] + 1);
      checkOutput("bp_resume_edge", e32, wr_cycle[1] + 1);
    end
    checkOutput("bp_count", vec_count, 16'd2);

    // Close in the very cycle the held vector drains.
    applyReset();
    clear_log();
    fifo_full = 1'b1;
    for (int i = 0; i < 31; i++) applyStimulus(N'(i), 1'b0, e);
    fifo_full = 1'b0;
    applyStimulus(16'd31, 1'b0, e31);
    idle(1);
    @(negedge clk);
    checkOutput("sim_ready", s_ready, 1'b1);
    idle(2);
    checkOutput("sim_writes", wr_data.size(), 2);
    if (wr_data.size() >= 2) begin
      checkOutput("sim_vec0", wr_data[0], make_vec(16'd0, 16));
      checkOutput("sim_vec1", wr_data[1], make_vec(16'd16, 16));
      checkOutput("sim_no_gap", wr_cycle[1], wr_cycle[0] + 1);
      checkOutput("sim_new_vec_cycle", wr_cycle[1], e31);
    end
    checkOutput("sim_count", vec_count, 16'd2);

    // Reset in the middle of a vector discards it.
    applyReset();
    clear_log();
    for (int i = 0; i < 7; i++) applyStimulus(16'h0100 + N'(i), 1'b0, e);
    applyReset();
    checkOutput("rstmid_no_write", wr_data.size(), 0);
    for (int i = 0; i < 16; i++) applyStimulus(16'h0200 + N'(i), 1'b0, e);
    idle(3);
    checkOutput("rstmid_writes", wr_data.size(), 1);
    if (wr_data.size() >= 1) begin
      checkOutput("rstmid_vec", wr_data[0], make_vec(16'h0200, 16));
    end
    checkOutput("rstmid_count", vec_count, 16'd1);

    // Counter wrap on the 2-bit instance.
    applyReset();
    clear_log();
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) applyStimulus(N'(v * 16 + i), 1'b0, e);
      idle(2);
      checkOutput($sformatf("wrap_cnt%0d", v), vec_count2, wrap_exp[v]);
    end
    checkOutput("wrap_wide_count", vec_count, 16'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
